// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RESP_RESEND  = 8'hFE;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    // Frame sent after the start bit, LSB first: data, odd parity, stop.
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus a falling-edge pulse.
// Flops reset high so an idle (released) line never produces a false edge.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronize the pad level and keep one older sample for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= line;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign fall  = prev_r & ~sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device clock falls and checks the device ACK.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int TIMEOUT_CYCLES = 1_300_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe_out,
    output logic       ps2_data_oe_out,
    output logic       done_out,
    output logic       error_out
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INHIBIT_LOAD = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    ps2_tx_state_t state_r;
    logic [CW-1:0] cnt_r;
    logic [3:0]    bitcnt_r;
    logic [9:0]    shift_r;
    logic          clk_oe_r;
    logic          data_oe_r;
    logic          ready_r;
    logic          done_r;
    logic          error_r;

    logic clk_sync_s;
    logic clk_fall_s;
    logic data_sync_s;
    logic unused_data_fall_s;
    logic timeout_s;

    ps2_line_sync u_clk_sync (
        .clk   (clk_in),
        .rst   (rst_in),
        .line  (ps2_clk_in),
        .level (clk_sync_s),
        .fall  (clk_fall_s)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk_in),
        .rst   (rst_in),
        .line  (ps2_data_in),
        .level (data_sync_s),
        .fall  (unused_data_fall_s)
    );

    // The watchdog expires when the counter would reach zero on this edge;
    // it is checked before any same-cycle clock fall.
    assign timeout_s = (cnt_r <= CNT_ONE);

    // Transfer sequencer with registered line enables and status pulses.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            bitcnt_r  <= 4'd0;
            shift_r   <= 10'd0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    ready_r   <= 1'b1;
                    if (valid_in && ready_r) begin
                        shift_r  <= ps2_frame(data_in);
                        cnt_r    <= INHIBIT_LOAD;
                        clk_oe_r <= 1'b1;
                        ready_r  <= 1'b0;
                        state_r  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt_r == '0) begin
                        data_oe_r <= 1'b1;
                        state_r   <= REQ;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                REQ: begin
                    // Release the clock; data stays low as the start bit.
                    clk_oe_r <= 1'b0;
                    bitcnt_r <= 4'd0;
                    cnt_r    <= TIMEOUT_LOAD;
                    state_r  <= SEND;
                end
                SEND: begin
                    if (timeout_s) begin
                        cnt_r     <= '0;
                        clk_oe_r  <= 1'b0;
                        data_oe_r <= 1'b0;
                        error_r   <= 1'b1;
                        ready_r   <= 1'b1;
                        state_r   <= IDLE;
                    end else if (clk_fall_s) begin
                        cnt_r    <= TIMEOUT_LOAD;
                        bitcnt_r <= bitcnt_r + 4'd1;
                        if (bitcnt_r == 4'd9) begin
                            data_oe_r <= 1'b0;
                            state_r   <= ACK;
                        end else begin
                            data_oe_r <= ~shift_r[bitcnt_r];
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ACK: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    if (timeout_s) begin
                        cnt_r   <= '0;
                        error_r <= 1'b1;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end else if (clk_fall_s) begin
                        if (!data_sync_s) begin
                            cnt_r   <= TIMEOUT_LOAD;
                            state_r <= WAIT_IDLE;
                        end else begin
                            error_r <= 1'b1;
                            ready_r <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                WAIT_IDLE: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    if (timeout_s) begin
                        cnt_r   <= '0;
                        error_r <= 1'b1;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end else if (clk_sync_s && data_sync_s) begin
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end else if (clk_fall_s) begin
                        cnt_r <= TIMEOUT_LOAD;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    cnt_r     <= '0;
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    ready_r   <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign ready_out       = ready_r;
    assign ps2_clk_oe_out  = clk_oe_r;
    assign ps2_data_oe_out = data_oe_r;
    assign done_out        = done_r;
    assign error_out       = error_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH = 20;
    localparam int TMO = 5000;
    localparam int H   = 10;    // device clock half period in system cycles

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out, clk_oe, data_oe, done_out, error_out;
    logic       bfm_clk_low = 1'b0;
    logic       bfm_data_low = 1'b0;
    logic       ps2_clk, ps2_data;

    // Wired-AND open-drain bus: either side may pull low.
    assign ps2_clk  = ~(clk_oe | bfm_clk_low);
    assign ps2_data = ~(data_oe | bfm_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .data_in         (data_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .ps2_clk_in      (ps2_clk),
        .ps2_data_in     (ps2_data),
        .ps2_clk_oe_out  (clk_oe),
        .ps2_data_oe_out (data_oe),
        .done_out        (done_out),
        .error_out       (error_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = 0;
    int done_base = 0, err_base = 0, last_fall_cyc = 0;
    int passed = 0, total = 0;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Count every cycle on which a status pulse is high.
    always @(negedge clk) begin
        if (done_out) done_cnt <= done_cnt + 1;
        if (error_out) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (done_out && error_out) both_cnt <= both_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       ack;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic begin_xfer(input logic [7:0] d);
        done_base = done_cnt;
        err_base  = err_cnt;
        @(negedge clk);
        data_in  = d;
        valid_in = 1'b1;
    endtask

    // Measures the inhibit window and the single request cycle.
    task automatic inhibit_check(input logic keep, input logic [7:0] next_d);
        int n = 0;
        int guard = 0;
        @(negedge clk);
        valid_in = keep;
        data_in  = next_d;
        while (clk_oe && !data_oe && guard < 100) begin
            n++;
            guard++;
            @(negedge clk);
        end
        chk("inhibit_len", n, INH);
        chk("req_cycle", {30'd0, clk_oe, data_oe}, 3);
        @(negedge clk);
        chk("start_bit_after_req", {30'd0, clk_oe, data_oe}, 1);
    endtask

    // Device side: clocks the frame in, optionally ACKs, may stop early.
    task automatic bfm(input int stop_edge, input logic ack, output logic [9:0] got);
        int n = 0;
        got = 10'd0;
        while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rts_seen", (n < 200) ? 1 : 0, 1);
        repeat (H) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) bfm_data_low = 1'b1;
            bfm_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (H) @(negedge clk);
            bfm_clk_low = 1'b0;
            repeat (H) @(negedge clk);
            if (k <= 10) got[k-1] = ps2_data;
            if (k == 11) bfm_data_low = 1'b0;
            if (k == stop_edge) break;
        end
    endtask

    // Waits (bounded) for the transfer outcome and checks pulse counts.
    task automatic finish_xfer(input string tag, input int exp_done, input int exp_err, input logic settle);
        int guard = 0;
        while ((done_cnt - done_base) + (err_cnt - err_base) == 0 && guard < TMO + 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk({tag, "_ready_at_end"}, ready_out, 1);
        if (settle) begin
            repeat (5) @(negedge clk);
            #1;
            chk({tag, "_oe_released"}, {30'd0, clk_oe, data_oe}, 0);
        end
        chk({tag, "_done_pulses"}, done_cnt - done_base, exp_done);
        chk({tag, "_error_pulses"}, err_cnt - err_base, exp_err);
    endtask

    task automatic chk_frame(input string tag, input logic [9:0] got, input logic [7:0] d, input logic par);
        chk({tag, "_data_bits"}, got[7:0], d);
        chk({tag, "_parity"}, got[8], par);
        chk({tag, "_stop"}, got[9], 1);
    endtask

    initial begin
        logic [9:0] got;

        vecs[0] = '{PS2_CMD_SET_LEDS, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{8'h00,            1'b1, 1'b1, 1, 0};
        vecs[2] = '{8'h01,            1'b0, 1'b1, 1, 0};
        vecs[3] = '{PS2_RESP_ACK,     1'b1, 1'b0, 0, 1};
        vecs[4] = '{PS2_RESP_RESEND,  1'b0, 1'b1, 1, 0};
        vecs[5] = '{8'h80,            1'b0, 1'b1, 1, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_oe", {30'd0, clk_oe, data_oe}, 0);
        chk("reset_pulses", {30'd0, done_out, error_out}, 0);
        rst_in = 1'b0;
        @(negedge clk);
        chk("reset_ready", ready_out, 1);

        // Table-driven transfers, with and without device ACK.
        for (int i = 0; i < 6; i++) begin
            begin_xfer(vecs[i].data);
            inhibit_check(1'b0, 8'h00);
            bfm(11, vecs[i].ack, got);
            chk_frame($sformatf("vec%0d", i), got, vecs[i].data, vecs[i].par);
            if (!vecs[i].ack) chk("noack_latency", err_cyc - last_fall_cyc, 3);
            finish_xfer($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err, 1'b1);
        end

        // Device stops clocking after the 4th edge: watchdog abort.
        begin_xfer(8'h5A);
        inhibit_check(1'b0, 8'h00);
        bfm(4, 1'b1, got);
        finish_xfer("timeout", 0, 1, 1'b1);
        chk("timeout_latency", err_cyc - last_fall_cyc, TMO + 3);

        // Reset in the middle of the data bits.
        begin_xfer(8'h3C);
        inhibit_check(1'b0, 8'h00);
        bfm(4, 1'b1, got);
        rst_in = 1'b1;
        @(negedge clk);
        chk("midreset_oe", {30'd0, clk_oe, data_oe}, 0);
        chk("midreset_pulses", {30'd0, done_out, error_out}, 0);
        rst_in = 1'b0;
        @(negedge clk);
        chk("midreset_ready", ready_out, 1);
        repeat (TMO + 50) @(negedge clk);
        #1;
        chk("midreset_no_late_pulse", (done_cnt - done_base) + (err_cnt - err_base), 0);

        // A normal send after the reset.
        begin_xfer(PS2_CMD_RESET);
        inhibit_check(1'b0, 8'h00);
        bfm(11, 1'b1, got);
        chk_frame("after_reset", got, PS2_CMD_RESET, 1'b1);
        finish_xfer("after_reset", 1, 0, 1'b1);

        // valid_in held through a transfer with a changed byte.
        begin_xfer(8'h12);
        inhibit_check(1'b1, 8'hF0);
        bfm(11, 1'b1, got);
        chk_frame("held_first", got, 8'h12, 1'b1);
        finish_xfer("held_first", 1, 0, 1'b0);
        done_base = done_cnt;
        err_base  = err_cnt;
        inhibit_check(1'b0, 8'h00);
        bfm(11, 1'b1, got);
        chk_frame("held_second", got, 8'hF0, 1'b1);
        finish_xfer("held_second", 1, 0, 1'b1);

        chk("done_error_exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
